id_ex_latch: RTL

ID_EX_LATCH -- requirements
Module: id_ex_latch

---
 rtl/id_ex_latch_pkg.sv | 73 +++++++
 rtl/id_ex_latch_if.sv | 66 ++++++
 rtl/id_ex_latch_load_use_detect.sv | 30 +++
 rtl/id_ex_latch.sv | 99 +++++++++
 4 files changed

// File: rtl/id_ex_latch_pkg.sv
`default_nettype none
//============================================================================
// Module  : cpu_types_pkg
// Purpose : Shared CPU types for the ID/EX pipeline latch: register index and
//           word types, ALU operation encoding, RegDst encodings, the packed
//           ID/EX stage record and the write-register select helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
//============================================================================
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;
   localparam int IMM_W  = 16;

   typedef logic [REG_W-1:0]  regbits_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   // RegDst encodings; the unused code 2'd3 falls back to rt
   localparam logic [1:0] REGDST_RT  = 2'd0;
   localparam logic [1:0] REGDST_RD  = 2'd1;
   localparam logic [1:0] REGDST_R31 = 2'd2;

   localparam regbits_t REG_RA = 5'd31;

   // Everything the ID/EX register carries except the sticky halt flag,
   // which has different update rules and lives beside it.
   typedef struct packed {
      logic             regwrite;
      logic             memtoreg;
      logic             dren;
      logic             dwen;
      logic             alusrc;
      logic [1:0]       regdst;
      aluop_t           aluop;
      regbits_t         rs;
      regbits_t         rt;
      regbits_t         rd;
      regbits_t         wsel;
      word_t            rdat1;
      word_t            rdat2;
      word_t            npc;
      logic [IMM_W-1:0] imm;
   } id_ex_t;

   function automatic regbits_t wsel_decode(input logic [1:0] regdst,
                                            input regbits_t   rt,
                                            input regbits_t   rd);
      regbits_t w_sel;
      case (regdst)
         REGDST_RT  : w_sel = rt;
         REGDST_RD  : w_sel = rd;
         REGDST_R31 : w_sel = REG_RA;
         default    : w_sel = rt;
      endcase
      return w_sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_latch_if.sv
`default_nettype none
//============================================================================
// Module  : id_ex_if
// Purpose : Bundle of decode-side inputs and EX-side registered outputs of the
//           ID/EX pipeline latch.
// Modports: latch    - the ID/EX register (consumes *_in, drives *_out_2)
//           datapath - surrounding CPU datapath (drives *_in, reads *_out_2)
//           tb       - testbench view, same directions as datapath
// Rev     : 1.0  initial release
//============================================================================
interface id_ex_if;
   import cpu_types_pkg::*;

   // decode side
   logic        en;
   logic        flush;
   regbits_t    rs_in, rt_in, rd_in;
   word_t       rdat1_in, rdat2_in, npc_in;
   logic [15:0] imm_in;
   logic        RegWrite_in, MemtoReg_in, dREN_in, dWEN_in, ALUSrc_in, halt_in;
   logic [1:0]  RegDst_in;
   aluop_t      ALUOp_in;

   // execute side
   regbits_t    rs_out_2, rt_out_2, rd_out_2, wsel_out_2;
   word_t       rdat1_out_2, rdat2_out_2, npc_out_2;
   logic [15:0] imm_out_2;
   logic        RegWrite_out_2, MemtoReg_out_2, dREN_out_2, dWEN_out_2;
   logic        ALUSrc_out_2, halt_out_2;
   logic [1:0]  RegDst_out_2;
   aluop_t      ALUOp_out_2;
   logic        stall;
   word_t       stall_cnt;

   modport latch (
      input  en, flush, rs_in, rt_in, rd_in, rdat1_in, rdat2_in, npc_in,
             imm_in, RegWrite_in, MemtoReg_in, dREN_in, dWEN_in, ALUSrc_in,
             halt_in, RegDst_in, ALUOp_in,
      output rs_out_2, rt_out_2, rd_out_2, wsel_out_2, rdat1_out_2,
             rdat2_out_2, npc_out_2, imm_out_2, RegWrite_out_2,
             MemtoReg_out_2, dREN_out_2, dWEN_out_2, ALUSrc_out_2,
             halt_out_2, RegDst_out_2, ALUOp_out_2, stall, stall_cnt
   );

   modport datapath (
      output en, flush, rs_in, rt_in, rd_in, rdat1_in, rdat2_in, npc_in,
             imm_in, RegWrite_in, MemtoReg_in, dREN_in, dWEN_in, ALUSrc_in,
             halt_in, RegDst_in, ALUOp_in,
      input  rs_out_2, rt_out_2, rd_out_2, wsel_out_2, rdat1_out_2,
             rdat2_out_2, npc_out_2, imm_out_2, RegWrite_out_2,
             MemtoReg_out_2, dREN_out_2, dWEN_out_2, ALUSrc_out_2,
             halt_out_2, RegDst_out_2, ALUOp_out_2, stall, stall_cnt
   );

   modport tb (
      output en, flush, rs_in, rt_in, rd_in, rdat1_in, rdat2_in, npc_in,
             imm_in, RegWrite_in, MemtoReg_in, dREN_in, dWEN_in, ALUSrc_in,
             halt_in, RegDst_in, ALUOp_in,
      input  rs_out_2, rt_out_2, rd_out_2, wsel_out_2, rdat1_out_2,
             rdat2_out_2, npc_out_2, imm_out_2, RegWrite_out_2,
             MemtoReg_out_2, dREN_out_2, dWEN_out_2, ALUSrc_out_2,
             halt_out_2, RegDst_out_2, ALUOp_out_2, stall, stall_cnt
   );

endinterface
`default_nettype wire

// File: rtl/id_ex_latch_load_use_detect.sv
`default_nettype none
//============================================================================
// Module  : load_use_detect
// Purpose : Combinational load-use hazard comparator. Flags when the load in
//           EX writes a register that the instruction in ID reads.
// Ports   : i_dren  - EX stage holds a load
//           i_wsel  - EX stage destination register
//           i_rs    - ID stage source register rs
//           i_rt    - ID stage source register rt
//           o_stall - hazard present, hold PC and IF/ID
// Rev     : 1.0  initial release
//============================================================================
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic     i_dren,
   input  regbits_t i_wsel,
   input  regbits_t i_rs,
   input  regbits_t i_rt,
   output logic     o_stall
);

   logic w_match;

   // $zero is never a real dependency, so a load targeting it cannot stall
   assign w_match = (i_wsel == i_rs) || (i_wsel == i_rt);
   assign o_stall = i_dren && (i_wsel != '0) && w_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_latch.sv
`default_nettype none
//============================================================================
// Module  : id_ex_latch
// Purpose : ID/EX pipeline register with bubble insertion on flush or
//           load-use hazard, sticky halt and a saturating load-use stall
//           counter.
// Ports   : CLK  - system clock, rising edge
//           nRST - asynchronous active-low reset
//           bus  - id_ex_if.latch: decode inputs, registered EX outputs,
//                  stall indication and stall counter
// Rev     : 1.0  initial release
//============================================================================
module id_ex_latch
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   id_ex_if.latch   bus
);

   id_ex_t   r_stage;
   logic     r_halt;
   word_t    r_stall_cnt;

   id_ex_t   w_load;
   logic     w_stall;
   logic     w_bubble;
   logic     w_cnt_inc;

   // Hazard check uses the registered EX contents, so reset clears dREN and
   // drops stall immediately without waiting for a clock.
   load_use_detect u_load_use_detect (
      .i_dren  (r_stage.dren),
      .i_wsel  (r_stage.wsel),
      .i_rs    (bus.rs_in),
      .i_rt    (bus.rt_in),
      .o_stall (w_stall)
   );

   always_comb begin
      w_load          = '0;
      w_load.regwrite = bus.RegWrite_in;
      w_load.memtoreg = bus.MemtoReg_in;
      w_load.dren     = bus.dREN_in;
      w_load.dwen     = bus.dWEN_in;
      w_load.alusrc   = bus.ALUSrc_in;
      w_load.regdst   = bus.RegDst_in;
      w_load.aluop    = bus.ALUOp_in;
      w_load.rs       = bus.rs_in;
      w_load.rt       = bus.rt_in;
      w_load.rd       = bus.rd_in;
      w_load.wsel     = wsel_decode(bus.RegDst_in, bus.rt_in, bus.rd_in);
      w_load.rdat1    = bus.rdat1_in;
      w_load.rdat2    = bus.rdat2_in;
      w_load.npc      = bus.npc_in;
      w_load.imm      = bus.imm_in;
   end

   assign w_bubble  = bus.flush || w_stall;
   // A stall that coincides with a flush is absorbed by the flush bubble
   assign w_cnt_inc = w_stall && !bus.flush && (r_stall_cnt != '1);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stage     <= '0;
         r_halt      <= 1'b0;
         r_stall_cnt <= '0;
      end else if (bus.en) begin
         r_stage <= w_bubble ? '0 : w_load;
         if (!w_bubble && bus.halt_in) begin
            r_halt <= 1'b1;
         end
         if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign bus.RegWrite_out_2 = r_stage.regwrite;
   assign bus.MemtoReg_out_2 = r_stage.memtoreg;
   assign bus.dREN_out_2     = r_stage.dren;
   assign bus.dWEN_out_2     = r_stage.dwen;
   assign bus.ALUSrc_out_2   = r_stage.alusrc;
   assign bus.RegDst_out_2   = r_stage.regdst;
   assign bus.ALUOp_out_2    = r_stage.aluop;
   assign bus.rs_out_2       = r_stage.rs;
   assign bus.rt_out_2       = r_stage.rt;
   assign bus.rd_out_2       = r_stage.rd;
   assign bus.wsel_out_2     = r_stage.wsel;
   assign bus.rdat1_out_2    = r_stage.rdat1;
   assign bus.rdat2_out_2    = r_stage.rdat2;
   assign bus.npc_out_2      = r_stage.npc;
   assign bus.imm_out_2      = r_stage.imm;
   assign bus.halt_out_2     = r_halt;
   assign bus.stall          = w_stall;
   assign bus.stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire
